y86_fetch_queue: RTL and testbench
==================================

Name: y86_fetch_queue

Overview:
Parametrised, sequential successor to the combinational Y86 fetch stage. It prefetches instruction bytes from an instruction memory port over a req/ack handshake and buffers them in a byte queue. It decodes the variable-length instruction at the queue head (1, 2, 9 or 10 bytes) and presents it to decode over a valid/ready handshake. It supports PC redirect (branch/return), halt, invalid-instruction and memory-bound error stop states.

Parameters:
ADDR_W, 64, PC/address width
MEM_BYTES, 4096, instruction memory size; bytes at address >= MEM_BYTES do not exist
FETCH_BYTES, 2, bytes returned per memory read (1, 2, 4 or 8)
QUEUE_BYTES, 16, byte queue depth; must be >= 10+FETCH_BYTES
RESET_PC, 0, fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
redirect  in  1  load new fetch PC, flush queue
redirect_pc  in  ADDR_W  new PC
mem_req  out  1  read request
mem_addr  out  ADDR_W  read byte address (unaligned allowed)
mem_ack  in  1  read data valid this cycle
mem_rdata  in  8*FETCH_BYTES  bytes mem_addr..mem_addr+FETCH_BYTES-1, byte 0 in [7:0]
out_valid  out  1  decoded instruction available
out_ready  in  1  consumer accepts
pc  out  ADDR_W  address of presented instruction
icode  out  4  head byte [7:4]
ifun  out  4  head byte [3:0]
rA  out  4  register A; 4'hF when absent
rB  out  4  register B; 4'hF when absent
valC  out  64  constant, little-endian; 0 when absent
valP  out  ADDR_W  pc + length
instr_validity  out  1  0 = illegal icode
imem_error  out  1  instruction extends past MEM_BYTES
hlt  out  1  presented instruction is halt

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- Reset (dominant over all other inputs):
  - queue empty, fetch_ptr=RESET_PC, state RUN.
  - All outputs 0, including mem_req. rA and rB also reset to 0.
- States:
  - RUN: fetching.
  - STOP: entered on acceptance of any instruction with hlt, !instr_validity or imem_error.
  - In STOP: mem_req=0, out_valid=0. Exit only via redirect (to RUN) or rst.
- Memory interface:
  - mem_req is registered. It asserts in RUN when no request is pending, fetch_ptr < MEM_BYTES and count+FETCH_BYTES <= QUEUE_BYTES.
  - mem_addr=fetch_ptr. Request and address are held stable until mem_ack; one request outstanding at most. Ack may arrive in the same cycle as req.
  - On ack: append bytes with address < MEM_BYTES (partial append at the top of memory), then fetch_ptr += FETCH_BYTES.
- Length by icode:
  - 0, 1, 9: 1 byte.
  - 2, 6, A, B: 2 bytes (rA/rB from byte1).
  - 3, 4, 5: 10 bytes (rA/rB byte1, valC bytes 2..9).
  - 7, 8: 9 bytes (valC bytes 1..8).
  - C..F: illegal; length 1, instr_validity=0.
- Output presentation:
  - out_valid=1 when state RUN and count >= length. All outputs derive from queue head.
  - out_valid is also 1 when fewer bytes remain but fetch_ptr >= MEM_BYTES and no request is pending. In that case imem_error=1; icode/ifun come from head, or are 0 if the queue is empty.
  - Fields are held stable while out_valid && !out_ready.
  - Accept (out_valid && out_ready) pops length bytes and advances pc to valP.
- Simultaneous events:
  - Accept and ack in the same cycle both apply, pop before push.
  - The free-space check uses the pre-pop count.
- Redirect (priority below rst):
  - Next cycle: queue empty, out_valid=0, mem_req=0, pc=fetch_ptr=redirect_pc, state RUN.
  - A pending request is withdrawn; an ack arriving in the redirect cycle is discarded.
  - If redirect_pc >= MEM_BYTES, the next valid output is imem_error with pc=redirect_pc.
- Latency: reset/redirect to first mem_req is 1 cycle. With a same-cycle ack, out_valid asserts in the cycle after the ack that completes the instruction.
- Arithmetic: valP and fetch_ptr wrap modulo 2^ADDR_W. A wrapped fetch_ptr is still bounds-checked against MEM_BYTES.

Test Plan:
- Stream test (FETCH_BYTES=2, ack always high). Memory 30 F4 00 01 00 00 00 00 00 00 10 00 gives:
  - irmovq: icode=3, ifun=0, rA=F, rB=4, valC=0x100, valP=10.
  - nop: pc=10, valP=11.
  - halt: hlt=1, valP=12.
  - Afterwards mem_req stays 0 and out_valid stays 0.
- Backpressure: hold out_ready=0 for 8 cycles after the first valid. Outputs are stable, and mem_req stops once count > 14. Release gives the same sequence with no bytes lost.
- Redirect to 0x20 in a cycle with mem_ack=1. The ack data is discarded, the next mem_addr is 0x20, and the first output has pc=0x20.
- MEM_BYTES=16, irmovq at address 12: one output with imem_error=1 and pc=12, then STOP. A redirect to 0 resumes fetching.
- Byte 0xC0 at pc=4: output instr_validity=0, valP=5, then STOP.
- Assert rst for 1 cycle while out_valid=1 mid-stream. Next cycle out_valid=0 and mem_req=0; the cycle after, mem_req=1 with mem_addr=RESET_PC.

Source files
------------

// File: rtl/y86_fetch_queue_if.sv
// Bus bundle for the Y86 fetch queue: instruction memory port, redirect
// input and the decoded-instruction output toward decode.
//
// Handshakes: a memory read transfers on any cycle where mem_req && mem_ack
// (ack may come in the same cycle as req; req/addr stay put until then).
// A decoded instruction transfers on any cycle where out_valid && out_ready;
// the fields stay stable while out_valid && !out_ready.
interface y86_fetch_queue_if #(
    parameter int ADDR_W      = 64,
    parameter int FETCH_BYTES = 2
);
    logic                     redirect;
    logic [ADDR_W-1:0]        redirect_pc;
    logic                     mem_req;
    logic [ADDR_W-1:0]        mem_addr;
    logic                     mem_ack;
    logic [8*FETCH_BYTES-1:0] mem_rdata;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDR_W-1:0]        pc;
    logic [3:0]               icode;
    logic [3:0]               ifun;
    logic [3:0]               rA;
    logic [3:0]               rB;
    logic [63:0]              valC;
    logic [ADDR_W-1:0]        valP;
    logic                     instr_validity;
    logic                     imem_error;
    logic                     hlt;
    logic                     state_dbg;

    modport master (
        input  redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
        output mem_req, mem_addr, out_valid, pc, icode, ifun, rA, rB,
               valC, valP, instr_validity, imem_error, hlt, state_dbg
    );

    modport slave (
        output redirect, redirect_pc, mem_ack, mem_rdata, out_ready,
        input  mem_req, mem_addr, out_valid, pc, icode, ifun, rA, rB,
               valC, valP, instr_validity, imem_error, hlt, state_dbg
    );
endinterface

// File: rtl/y86_fetch_queue.sv
// Sequential Y86 fetch stage: prefetches bytes into a shifting byte queue,
// decodes the variable-length instruction at the head and hands it to decode.
// Stops after halt, an illegal icode or a fetch past the end of memory until
// a redirect restarts it.
module y86_fetch_queue #(
    parameter int                ADDR_W      = 64,
    parameter int                MEM_BYTES   = 4096,
    parameter int                FETCH_BYTES = 2,
    parameter int                QUEUE_BYTES = 16,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
    input logic               clk,
    input logic               rst,
    y86_fetch_queue_if.master bus
);
    localparam int                CW      = $clog2(QUEUE_BYTES + 1);
    localparam logic [ADDR_W-1:0] MEM_LIM = ADDR_W'(MEM_BYTES);

    typedef enum logic {ST_RUN = 1'b0, ST_STOP = 1'b1} state_t;

    state_t            state;
    logic [7:0]        q [QUEUE_BYTES];
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] fetch_ptr;
    logic [ADDR_W-1:0] pc_q;
    logic              mem_req_q;
    logic              settle;      // one quiet cycle after reset/redirect

    logic [3:0]        h_icode, h_ifun;
    logic [3:0]        len;
    logic              has_rr;
    logic [1:0]        c_sel;       // 0: no valC, 1: from byte 1, 2: from byte 2
    logic              full, at_end, valid_int, bad, accept, take_ack, stop_now;
    logic [63:0]       d_valC;
    logic [ADDR_W-1:0] d_valP;
    logic [CW-1:0]     pop_n, nb, cnt_n;
    logic [7:0]        q_n [QUEUE_BYTES];
    logic [ADDR_W-1:0] fp_n;
    logic              space_ok, req_n;

    // Decode the instruction sitting at the queue head.
    always_comb begin
        h_icode = (count != '0) ? q[0][7:4] : 4'h0;
        h_ifun  = (count != '0) ? q[0][3:0] : 4'h0;
        len     = 4'd1;
        has_rr  = 1'b0;
        c_sel   = 2'd0;
        case (h_icode)
            4'h2, 4'h6, 4'hA, 4'hB: begin len = 4'd2;  has_rr = 1'b1; end
            4'h3, 4'h4, 4'h5:       begin len = 4'd10; has_rr = 1'b1; c_sel = 2'd2; end
            4'h7, 4'h8:             begin len = 4'd9;  c_sel = 2'd1; end
            default:                len = 4'd1;
        endcase
        bad    = (h_icode >= 4'hC);
        full   = (int'(count) >= int'(len));
        at_end = (fetch_ptr >= MEM_LIM) && !mem_req_q;
        d_valC = '0;
        for (int k = 0; k < 8; k++) begin
            if (c_sel == 2'd1)
                d_valC[k*8 +: 8] = q[k+1];
            else if (c_sel == 2'd2)
                d_valC[k*8 +: 8] = q[k+2];
        end
        d_valP    = pc_q + ADDR_W'(len);
        valid_int = (state == ST_RUN) && !settle && (full || at_end);
        accept    = valid_int && bus.out_ready;
        stop_now  = accept && (!full || bad || (h_icode == 4'h0));
        take_ack  = mem_req_q && bus.mem_ack && (state == ST_RUN);
    end

    // Next queue contents: pop the accepted instruction, then append the
    // in-range bytes of a returning read behind what is left.
    always_comb begin
        nb = '0;
        for (int j = 0; j < FETCH_BYTES; j++) begin
            if (fetch_ptr + ADDR_W'(j) < MEM_LIM)
                nb = nb + CW'(1);
        end
        pop_n = full ? CW'(len) : count;
        q_n   = q;
        cnt_n = count;
        if (accept) begin
            for (int i = 0; i < QUEUE_BYTES; i++) begin
                if (i + int'(pop_n) < QUEUE_BYTES)
                    q_n[i] = q[i + int'(pop_n)];
                else
                    q_n[i] = 8'h00;
            end
            cnt_n = count - pop_n;
        end
        if (take_ack) begin
            for (int i = 0; i < QUEUE_BYTES; i++) begin
                if (i >= int'(cnt_n) && i < int'(cnt_n) + int'(nb))
                    q_n[i] = bus.mem_rdata[(i - int'(cnt_n))*8 +: 8];
            end
            cnt_n = cnt_n + nb;
        end
    end

    // Next request: hold a pending one until ack, otherwise issue when the
    // next address is in memory and the pre-pop fill leaves room for a read.
    always_comb begin
        fp_n     = take_ack ? fetch_ptr + ADDR_W'(FETCH_BYTES) : fetch_ptr;
        space_ok = (int'(count) + (take_ack ? int'(nb) : 0) + FETCH_BYTES) <= QUEUE_BYTES;
        if (mem_req_q && !bus.mem_ack)
            req_n = 1'b1;
        else
            req_n = (fp_n < MEM_LIM) && space_ok;
    end

    // Run/stop control, queue, pointers and the registered memory request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            count     <= '0;
            fetch_ptr <= RESET_PC;
            pc_q      <= RESET_PC;
            mem_req_q <= 1'b0;
            settle    <= 1'b1;
        end else if (bus.redirect) begin
            state     <= ST_RUN;
            count     <= '0;
            fetch_ptr <= bus.redirect_pc;
            pc_q      <= bus.redirect_pc;
            mem_req_q <= 1'b0;
            settle    <= 1'b1;
        end else begin
            settle    <= 1'b0;
            q         <= q_n;
            count     <= cnt_n;
            fetch_ptr <= fp_n;
            if (accept)
                pc_q <= d_valP;
            case (state)
                ST_RUN: begin
                    if (stop_now) begin
                        state     <= ST_STOP;
                        mem_req_q <= 1'b0;
                    end else begin
                        mem_req_q <= req_n;
                    end
                end
                default: mem_req_q <= 1'b0;
            endcase
        end
    end

    assign bus.mem_req        = mem_req_q;
    assign bus.mem_addr       = fetch_ptr;
    assign bus.out_valid      = valid_int;
    assign bus.pc             = pc_q;
    assign bus.icode          = valid_int ? h_icode : 4'h0;
    assign bus.ifun           = valid_int ? h_ifun  : 4'h0;
    assign bus.rA             = valid_int ? ((has_rr && full) ? q[1][7:4] : 4'hF) : 4'h0;
    assign bus.rB             = valid_int ? ((has_rr && full) ? q[1][3:0] : 4'hF) : 4'h0;
    assign bus.valC           = (valid_int && full) ? d_valC : 64'h0;
    assign bus.valP           = valid_int ? d_valP : '0;
    assign bus.instr_validity = valid_int && !bad;
    assign bus.imem_error     = valid_int && !full;
    assign bus.hlt            = valid_int && full && (h_icode == 4'h0);
    assign bus.state_dbg      = state;
endmodule

// File: tb/tb_y86_fetch_queue.sv
// Directed bench for y86_fetch_queue: one instance with a 4 KiB memory and
// one with a 16-byte memory, each fed by a byte-array memory model.
module tb_y86_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    y86_fetch_queue_if #(.ADDR_W(64), .FETCH_BYTES(2)) fa ();
    y86_fetch_queue_if #(.ADDR_W(64), .FETCH_BYTES(2)) fb ();

    y86_fetch_queue #(.ADDR_W(64), .MEM_BYTES(4096), .FETCH_BYTES(2), .QUEUE_BYTES(16))
        dut_a (.clk(clk), .rst(rst), .bus(fa));
    y86_fetch_queue #(.ADDR_W(64), .MEM_BYTES(16), .FETCH_BYTES(2), .QUEUE_BYTES(16))
        dut_b (.clk(clk), .rst(rst), .bus(fb));

    logic [7:0]  mem_a [4096];
    logic [7:0]  mem_b [16];
    logic        ack_a = 1'b1;
    logic        ack_b = 1'b1;
    logic        rand_mode = 1'b0;
    logic [63:0] aj_a, aj_b;

    assign fa.mem_ack = fa.mem_req & ack_a;
    assign fb.mem_ack = fb.mem_req & ack_b;

    // memory models: bytes past the end of memory read as junk
    always_comb begin
        fa.mem_rdata = '0;
        fb.mem_rdata = '0;
        aj_a = '0;
        aj_b = '0;
        for (int j = 0; j < 2; j++) begin
            aj_a = fa.mem_addr + 64'(j);
            aj_b = fb.mem_addr + 64'(j);
            fa.mem_rdata[j*8 +: 8] = (aj_a < 64'd4096) ? mem_a[aj_a[11:0]] : 8'hEE;
            fb.mem_rdata[j*8 +: 8] = (aj_b < 64'd16)   ? mem_b[aj_b[3:0]]   : 8'hEE;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [255:0] exp_a[$];
    logic [255:0] exp_b[$];

    function automatic logic [255:0] mk(logic [63:0] pc, logic [3:0] ic, logic [3:0] fn,
                                       logic [3:0] ra, logic [3:0] rb, logic [63:0] vc,
                                       logic [63:0] vp, logic v, logic e, logic h);
        return 256'({pc, ic, fn, ra, rb, vc, vp, v, e, h});
    endfunction

    function automatic logic [255:0] obs_a();
        return mk(fa.pc, fa.icode, fa.ifun, fa.rA, fa.rB, fa.valC, fa.valP,
                  fa.instr_validity, fa.imem_error, fa.hlt);
    endfunction

    function automatic logic [255:0] obs_b();
        return mk(fb.pc, fb.icode, fb.ifun, fb.rA, fb.rB, fb.valC, fb.valP,
                  fb.instr_validity, fb.imem_error, fb.hlt);
    endfunction

    task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every accept, then advance one clock (negedge to negedge).
    task automatic tick();
        if (rand_mode) begin
            ack_a        = 1'($urandom_range(0, 1));
            fa.out_ready = 1'($urandom_range(0, 1));
        end
        if (fa.out_valid && fa.out_ready && !fa.redirect && !rst) begin
            chk("a_exp_pending", 256'(exp_a.size() != 0), 256'(1));
            if (exp_a.size() != 0) chk("a_out", obs_a(), exp_a.pop_front());
        end
        if (fb.out_valid && fb.out_ready && !fb.redirect && !rst) begin
            chk("b_exp_pending", 256'(exp_b.size() != 0), 256'(1));
            if (exp_b.size() != 0) chk("b_out", obs_b(), exp_b.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(string tag, int max_cycles);
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, 256'(exp_a.size() + exp_b.size()), 256'(0));
    endtask

    task automatic wait_valid(string tag, logic use_b, int max_cycles);
        int n = 0;
        while (!(use_b ? fb.out_valid : fa.out_valid) && n < max_cycles) begin
            tick();
            n++;
        end
        chk(tag, 256'(use_b ? fb.out_valid : fa.out_valid), 256'(1));
    endtask

    task automatic redirect_a(logic [63:0] npc);
        fa.redirect    = 1'b1;
        fa.redirect_pc = npc;
        tick();
        fa.redirect    = 1'b0;
    endtask

    task automatic redirect_b(logic [63:0] npc);
        fb.redirect    = 1'b1;
        fb.redirect_pc = npc;
        tick();
        fb.redirect    = 1'b0;
    endtask

    task automatic push_stream_a();
        exp_a.push_back(mk(64'd0,  4'h3, 4'h0, 4'hF, 4'h4, 64'h100, 64'd10, 1'b1, 1'b0, 1'b0));
        exp_a.push_back(mk(64'd10, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,   64'd11, 1'b1, 1'b0, 1'b0));
        exp_a.push_back(mk(64'd11, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,   64'd12, 1'b1, 1'b0, 1'b1));
    endtask

    initial begin
        logic [7:0] prog_a [12];
        logic [7:0] prog_j [12];
        prog_a = '{8'h30, 8'hF4, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00};
        prog_j = '{8'h60, 8'h12, 8'h70, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 4096; i++) mem_a[i] = 8'h10;
        for (int i = 0; i < 12; i++) begin
            mem_a[i]        = prog_a[i];
            mem_a[32 + i]   = prog_j[i];
        end
        for (int i = 0; i < 16; i++) mem_b[i] = 8'h10;
        mem_b[4]  = 8'hC0;
        mem_b[12] = 8'h30;
        mem_b[13] = 8'hF4;
        mem_b[14] = 8'h00;
        mem_b[15] = 8'h01;

        fa.redirect = 1'b0; fa.redirect_pc = '0; fa.out_ready = 1'b0;
        fb.redirect = 1'b0; fb.redirect_pc = '0; fb.out_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid",   256'(fa.out_valid), 256'(0));
        chk("rst_req",     256'(fa.mem_req),   256'(0));
        chk("rst_rA",      256'(fa.rA),        256'(0));
        chk("rst_rB",      256'(fa.rB),        256'(0));
        chk("rst_pc",      256'(fa.pc),        256'(0));
        chk("rst_state",   256'(fa.state_dbg), 256'(0));
        rst = 1'b0;
        fa.out_ready = 1'b1;
        push_stream_a();
        chk("rst_req_c0",  256'(fa.mem_req),   256'(0));
        tick();
        chk("rst_req_c1",  256'(fa.mem_req),   256'(1));
        chk("rst_addr_c1", 256'(fa.mem_addr),  256'(0));

        // stream: irmovq, nop, halt, then stopped
        drain("stream_drain", 40);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stop_valid", 256'(fa.out_valid), 256'(0));
            chk("stop_req",   256'(fa.mem_req),   256'(0));
        end
        chk("stop_state", 256'(fa.state_dbg), 256'(1));

        // backpressure: fields hold, fetch stops when the queue fills
        fa.out_ready = 1'b0;
        redirect_a(64'd0);
        push_stream_a();
        wait_valid("bp_valid", 1'b0, 40);
        for (int i = 0; i < 8; i++) begin
            chk("bp_hold", obs_a(), exp_a[0]);
            tick();
        end
        chk("bp_req_stop", 256'(fa.mem_req), 256'(0));
        fa.out_ready = 1'b1;
        drain("bp_drain", 40);

        // random ack and ready
        redirect_a(64'd0);
        push_stream_a();
        rand_mode = 1'b1;
        drain("rand_drain", 400);
        rand_mode = 1'b0;
        ack_a = 1'b1;

        // redirect in a cycle with an ack: data dropped, restart at 0x20
        fa.out_ready = 1'b0;
        redirect_a(64'd0);
        tick();
        chk("rd_req_pre", 256'(fa.mem_req), 256'(1));
        redirect_a(64'h20);
        chk("rd_valid",   256'(fa.out_valid), 256'(0));
        chk("rd_req",     256'(fa.mem_req),   256'(0));
        chk("rd_pc",      256'(fa.pc),        256'(64'h20));
        tick();
        chk("rd_req_c1",  256'(fa.mem_req),   256'(1));
        chk("rd_addr_c1", 256'(fa.mem_addr),  256'(64'h20));
        exp_a.push_back(mk(64'h20, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0,    64'h22, 1'b1, 1'b0, 1'b0));
        exp_a.push_back(mk(64'h22, 4'h7, 4'h0, 4'hF, 4'hF, 64'h1234, 64'h2B, 1'b1, 1'b0, 1'b0));
        exp_a.push_back(mk(64'h2B, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,    64'h2C, 1'b1, 1'b0, 1'b1));
        fa.out_ready = 1'b1;
        drain("rd_drain", 60);

        // illegal byte 0xC0 at pc 4, then stop
        fb.out_ready = 1'b0;
        redirect_b(64'd0);
        for (int i = 0; i < 4; i++)
            exp_b.push_back(mk(64'(i), 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'(i + 1), 1'b1, 1'b0, 1'b0));
        exp_b.push_back(mk(64'd4, 4'hC, 4'h0, 4'hF, 4'hF, 64'h0, 64'd5, 1'b0, 1'b0, 1'b0));
        fb.out_ready = 1'b1;
        drain("inv_drain", 60);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("inv_stop_valid", 256'(fb.out_valid), 256'(0));
            chk("inv_stop_req",   256'(fb.mem_req),   256'(0));
        end

        // irmovq truncated by the end of a 16-byte memory
        fb.out_ready = 1'b0;
        redirect_b(64'd12);
        exp_b.push_back(mk(64'd12, 4'h3, 4'h0, 4'hF, 4'hF, 64'h0, 64'd22, 1'b1, 1'b1, 1'b0));
        fb.out_ready = 1'b1;
        drain("mem_err_drain", 40);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mem_err_stop_valid", 256'(fb.out_valid), 256'(0));
            chk("mem_err_stop_req",   256'(fb.mem_req),   256'(0));
        end
        fb.out_ready = 1'b0;
        redirect_b(64'd0);
        chk("resume_req_c0",  256'(fb.mem_req), 256'(0));
        tick();
        chk("resume_req_c1",  256'(fb.mem_req),  256'(1));
        chk("resume_addr_c1", 256'(fb.mem_addr), 256'(0));
        wait_valid("resume_valid", 1'b1, 20);
        chk("resume_out", obs_b(), mk(64'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'd1, 1'b1, 1'b0, 1'b0));

        // redirect beyond memory: immediate imem_error at the new pc
        redirect_b(64'h20);
        chk("oob_valid_c0", 256'(fb.out_valid), 256'(0));
        tick();
        chk("oob_req", 256'(fb.mem_req), 256'(0));
        exp_b.push_back(mk(64'h20, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 1'b1, 1'b1, 1'b0));
        fb.out_ready = 1'b1;
        drain("oob_drain", 20);

        // valP wraps at the top of the address space
        fb.out_ready = 1'b0;
        redirect_b(64'hFFFF_FFFF_FFFF_FFFF);
        exp_b.push_back(mk(64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0,
                           1'b1, 1'b1, 1'b0));
        fb.out_ready = 1'b1;
        drain("wrap_drain", 20);
        fb.out_ready = 1'b0;

        // reset mid-stream while an instruction is presented
        fa.out_ready = 1'b0;
        redirect_a(64'd0);
        wait_valid("mid_rst_valid", 1'b0, 40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid_c0", 256'(fa.out_valid), 256'(0));
        chk("mid_rst_req_c0",   256'(fa.mem_req),   256'(0));
        tick();
        chk("mid_rst_req_c1",   256'(fa.mem_req),   256'(1));
        chk("mid_rst_addr_c1",  256'(fa.mem_addr),  256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
